// File: rtl/fifo_modport.sv
// fifo_modport: single-clock 32x32 FIFO whose flags and levels come from registered pointers only
module fifo_modport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  rclk,
    input  logic                  sw_rst,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] afull_value,
    output logic                  wfull,
    output logic                  wr_almost_full,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   fifo_write_count,
    output logic [ADDR_WIDTH:0]   wr_level,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] aempty_value,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  rdempty,
    output logic                  rd_almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   fifo_read_count,
    output logic [ADDR_WIDTH:0]   rd_level
);
    localparam int PW = ADDR_WIDTH + 1;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wcnt_q, wcnt_d, rcnt_q, rcnt_d, level;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic ovf_q, ovf_d, unf_q, unf_d, wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    always_comb begin
        level           = wptr_q - rptr_q;
        rdempty         = level == '0;
        wfull           = level == PW'(DEPTH);
        rd_almost_empty = level <= {1'b0, aempty_value};
        wr_almost_full  = (PW'(DEPTH) - level) <= {1'b0, afull_value};
        wr_acc          = write_enable && !wfull;
        rd_acc          = read_enable && !rdempty;
        wptr_d          = wptr_q + PW'(wr_acc);
        rptr_d          = rptr_q + PW'(rd_acc);
        wcnt_d          = wcnt_q + PW'(wr_acc);
        rcnt_d          = rcnt_q + PW'(rd_acc);
        rdata_d         = rd_acc ? mem_q[rptr_q[ADDR_WIDTH-1:0]] : rdata_q;
        ovf_d           = write_enable && wfull;
        unf_d           = read_enable && rdempty;
    end
    always_ff @(posedge rclk) begin
        if (sw_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            rdata_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
    always_ff @(posedge rclk) begin
        if (wr_acc && !sw_rst) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= write_data;
    end
    assign wr_level         = level;
    assign rd_level         = level;
    assign fifo_write_count = wcnt_q;
    assign fifo_read_count  = rcnt_q;
    assign read_data        = rdata_q;
    assign overflow         = ovf_q;
    assign underflow        = unf_q;
endmodule

// File: tb/tb_fifo_modport.sv
// tb_fifo_modport: directed and random checks of fifo_modport against a queue-based model
module tb_fifo_modport;
    logic        rclk = 1'b0;
    logic        sw_rst, write_enable, read_enable;
    logic [31:0] write_data;
    logic [4:0]  afull_value, aempty_value;
    logic        wfull, wr_almost_full, overflow, rdempty, rd_almost_empty, underflow;
    logic [5:0]  fifo_write_count, wr_level, fifo_read_count, rd_level;
    logic [31:0] read_data;
    logic [61:0] got;
    int          errs = 0, checks = 0;
    logic [31:0] q[$];
    logic [5:0]  m_wc, m_rc;
    logic [31:0] m_rd;
    logic        m_ovf, m_unf;

    fifo_modport dut (
        .rclk(rclk), .sw_rst(sw_rst), .write_enable(write_enable), .write_data(write_data),
        .afull_value(afull_value), .wfull(wfull), .wr_almost_full(wr_almost_full),
        .overflow(overflow), .fifo_write_count(fifo_write_count), .wr_level(wr_level),
        .read_enable(read_enable), .aempty_value(aempty_value), .read_data(read_data),
        .rdempty(rdempty), .rd_almost_empty(rd_almost_empty), .underflow(underflow),
        .fifo_read_count(fifo_read_count), .rd_level(rd_level)
    );

    always #5 rclk = ~rclk;

    assign got = {rdempty, wfull, rd_almost_empty, wr_almost_full, overflow, underflow,
                  fifo_write_count, fifo_read_count, rd_level, wr_level, read_data};

    function automatic logic [61:0] expv();
        int lvl = q.size();
        return {lvl == 0, lvl == 32, lvl <= int'(aempty_value), (32 - lvl) <= int'(afull_value),
                m_ovf, m_unf, m_wc, m_rc, 6'(lvl), 6'(lvl), m_rd};
    endfunction

    task automatic step(input logic r, input logic we, input logic re, input logic [31:0] wd);
        bit full, empty;
        sw_rst = r; write_enable = we; read_enable = re; write_data = wd;
        @(posedge rclk);
        full = q.size() == 32;
        empty = q.size() == 0;
        if (r) begin
            q.delete(); m_wc = 0; m_rc = 0; m_rd = 0; m_ovf = 0; m_unf = 0;
        end else begin
            m_ovf = we && full;
            m_unf = re && empty;
            if (re && !empty) begin m_rd = q.pop_front(); m_rc = m_rc + 6'd1; end
            if (we && !full) begin q.push_back(wd); m_wc = m_wc + 6'd1; end
        end
        #1;
    endtask

    task automatic test_reset();
        afull_value = 5'd31; aempty_value = 5'd3;
        step(1, 1, 1, 32'hDEAD_BEEF);
        step(1, 1, 1, 32'hDEAD_BEEF);
        checks++;
        if (got !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 32'd0}) begin
            errs++; $display("FAIL reset_state got %h exp rdempty=1 rae=1 rest 0", got);
        end
        checks++;
        if (got !== expv()) begin errs++; $display("FAIL reset_model got %h exp %h", got, expv()); end
    endtask

    task automatic test_single();
        step(0, 1, 0, 32'hA5A5_0001);
        step(0, 0, 1, 32'h0);
        checks++;
        if (read_data !== 32'hA5A5_0001) begin
            errs++; $display("FAIL single_data got %h exp a5a50001", read_data);
        end
        checks++;
        if ({rdempty, fifo_read_count, fifo_write_count} !== {1'b1, 6'd1, 6'd1}) begin
            errs++; $display("FAIL single_status got e=%b rc=%0d wc=%0d exp e=1 rc=1 wc=1",
                             rdempty, fifo_read_count, fifo_write_count);
        end
    endtask

    task automatic test_fill_overflow();
        afull_value = 5'd2;
        for (int i = 0; i < 33; i++) begin
            int lvl = (i + 1 > 32) ? 32 : i + 1;
            step(0, 1, 0, $urandom);
            checks++;
            if ({wr_almost_full, wfull, overflow} !== {lvl >= 30, lvl == 32, i == 32}) begin
                errs++; $display("FAIL fill_flags write=%0d got af=%b full=%b ovf=%b exp af=%b full=%b ovf=%b",
                                 i, wr_almost_full, wfull, overflow, lvl >= 30, lvl == 32, i == 32);
            end
            checks++;
            if (got !== expv()) begin errs++; $display("FAIL fill_model write=%0d got %h exp %h", i, got, expv()); end
        end
        checks++;
        if (wr_level !== 6'd32) begin errs++; $display("FAIL fill_level got %0d exp 32", wr_level); end
        step(0, 0, 0, 0);
        checks++;
        if (overflow !== 1'b0) begin errs++; $display("FAIL ovf_clear got %b exp 0", overflow); end
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 1, 0);
            checks++;
            if (got !== expv()) begin errs++; $display("FAIL drain_model read=%0d got %h exp %h", i, got, expv()); end
        end
    endtask

    task automatic test_underflow();
        logic [31:0] held = m_rd;
        logic [5:0]  rc = m_rc;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            checks++;
            if ({underflow, read_data, fifo_read_count} !== {1'b1, held, rc}) begin
                errs++; $display("FAIL underflow cyc=%0d got unf=%b rd=%h rc=%0d exp unf=1 rd=%h rc=%0d",
                                 i, underflow, read_data, fifo_read_count, held, rc);
            end
        end
        step(0, 0, 0, 0);
        checks++;
        if (underflow !== 1'b0) begin errs++; $display("FAIL unf_clear got %b exp 0", underflow); end
    endtask

    task automatic test_almost_empty();
        aempty_value = 5'd4;
        for (int i = 0; i < 6; i++) step(0, 1, 0, $urandom);
        checks++;
        if ({rd_level, rd_almost_empty} !== {6'd6, 1'b0}) begin
            errs++; $display("FAIL ae_6 got lvl=%0d ae=%b exp lvl=6 ae=0", rd_level, rd_almost_empty);
        end
        step(0, 0, 1, 0);
        checks++;
        if ({rd_level, rd_almost_empty} !== {6'd5, 1'b0}) begin
            errs++; $display("FAIL ae_5 got lvl=%0d ae=%b exp lvl=5 ae=0", rd_level, rd_almost_empty);
        end
        step(0, 0, 1, 0);
        checks++;
        if ({rd_level, rd_almost_empty} !== {6'd4, 1'b1}) begin
            errs++; $display("FAIL ae_4 got lvl=%0d ae=%b exp lvl=4 ae=1", rd_level, rd_almost_empty);
        end
        while (q.size() > 0) step(0, 0, 1, 0);
    endtask

    task automatic test_stream();
        for (int i = 0; i < 10; i++) step(0, 1, 0, $urandom);
        for (int i = 0; i < 30; i++) begin
            step(0, 1, 1, $urandom);
            checks++;
            if ({rd_level, read_data} !== {6'd10, m_rd}) begin
                errs++; $display("FAIL stream cyc=%0d got lvl=%0d rd=%h exp lvl=10 rd=%h",
                                 i, rd_level, read_data, m_rd);
            end
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0);
            checks++;
            if (got !== expv()) begin errs++; $display("FAIL stream_drain i=%0d got %h exp %h", i, got, expv()); end
        end
        for (int i = 0; i < 10; i++) step(0, 1, 0, $urandom);
        step(1, 1, 1, $urandom);
        checks++;
        if ({rd_level, wr_level, rdempty} !== {6'd0, 6'd0, 1'b1}) begin
            errs++; $display("FAIL mid_reset got lvl=%0d/%0d e=%b exp 0/0 e=1", rd_level, wr_level, rdempty);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            afull_value = 5'($urandom);
            aempty_value = 5'($urandom);
            step($urandom_range(0, 79) == 0, $urandom_range(0, 9) < (i % 200 < 100 ? 7 : 3),
                 $urandom_range(0, 9) < (i % 200 < 100 ? 3 : 7), $urandom);
            checks++;
            if (got !== expv()) begin errs++; $display("FAIL random cyc=%0d got %h exp %h", i, got, expv()); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_underflow();
        test_almost_empty();
        test_stream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
